// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller: interval codes, timer
// states and the default phase durations in seconds.
package traffic_pkg;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;
  localparam logic [1:0] INT_RSVD = 2'b11;

  localparam int T_BASE_DEF_SEC = 6;
  localparam int T_EXT_DEF_SEC  = 3;
  localparam int T_YEL_DEF_SEC  = 2;

  typedef enum logic [1:0] {
    TMR_IDLE   = 2'b00,
    TMR_RUN    = 2'b01,
    TMR_EXPIRE = 2'b10
  } timer_state_e;

  // The reserved selector code never addresses a parameter register.
  function automatic logic prog_sel_valid(input logic [1:0] sel);
    return (sel != INT_RSVD);
  endfunction

endpackage

// File: rtl/interval_timer_ctrl_sec_prescaler.sv
// Clock-to-seconds prescaler: counts 0..CLK_PER_SEC-1 while enabled and
// flags the last count of each second.
module sec_prescaler #(
  parameter int CLK_PER_SEC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PS_W = $clog2(CLK_PER_SEC);
  localparam logic [PS_W-1:0] LAST_CNT = PS_W'(CLK_PER_SEC - 1);

  logic [PS_W-1:0] cnt_q;
  logic [PS_W-1:0] cnt_d;

  // Next count: clear wins over counting; hold when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PS_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decoded from the register only, so no input reaches tick combinationally.
  assign tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer behind the traffic FSM: holds the programmable durations,
// loads one on start_timer and counts it down in one-second ticks.
module interval_timer_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_PER_SEC = 4,
  parameter int CNT_W       = 4,
  parameter int T_BASE_DEF  = T_BASE_DEF_SEC,
  parameter int T_EXT_DEF   = T_EXT_DEF_SEC,
  parameter int T_YEL_DEF   = T_YEL_DEF_SEC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_write,
  input  logic [1:0]       prog_sel,
  input  logic [CNT_W-1:0] prog_value,
  input  logic             reprogram,
  input  logic [1:0]       requesting_interval,
  input  logic             start_timer,
  output logic             expired,
  output logic             busy,
  output logic             sec_tick,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] BASE_RST = CNT_W'(T_BASE_DEF);
  localparam logic [CNT_W-1:0] EXT_RST  = CNT_W'(T_EXT_DEF);
  localparam logic [CNT_W-1:0] YEL_RST  = CNT_W'(T_YEL_DEF);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] t_base_q, t_base_d;
  logic [CNT_W-1:0] t_ext_q, t_ext_d;
  logic [CNT_W-1:0] t_yel_q, t_yel_d;
  logic             expired_q, expired_d;
  logic             busy_q, busy_d;
  logic             tick_s;
  logic             wr_ok_s;
  logic [CNT_W-1:0] load_val_s;

  function automatic logic [CNT_W-1:0] pick_interval(
    input logic [1:0]       req,
    input logic [CNT_W-1:0] base,
    input logic [CNT_W-1:0] ext,
    input logic [CNT_W-1:0] yel
  );
    case (req)
      INT_EXT: return ext;
      INT_YEL: return yel;
      default: return base;
    endcase
  endfunction

  sec_prescaler #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .enable(state_q == TMR_RUN),
    .clear (start_timer | reprogram),
    .tick  (tick_s)
  );

  assign wr_ok_s    = prog_write && prog_sel_valid(prog_sel) && (prog_value != '0);
  // Loads read the registered parameters, so a same-edge write lands afterwards.
  assign load_val_s = pick_interval(requesting_interval, t_base_q, t_ext_q, t_yel_q);

  // Parameter register next-state: zero durations are rejected.
  always_comb begin
    t_base_d = t_base_q;
    t_ext_d  = t_ext_q;
    t_yel_d  = t_yel_q;
    if (wr_ok_s) begin
      case (prog_sel)
        INT_BASE: t_base_d = prog_value;
        INT_EXT:  t_ext_d  = prog_value;
        INT_YEL:  t_yel_d  = prog_value;
        default:  t_base_d = t_base_q;
      endcase
    end else begin
      t_base_d = t_base_q;
    end
  end

  // Timer FSM next-state and countdown; reprogram overrides start_timer.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      TMR_IDLE: begin
        state_d = TMR_IDLE;
      end
      TMR_RUN: begin
        if (tick_s) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = TMR_EXPIRE;
          end else begin
            state_d = TMR_RUN;
          end
        end else begin
          state_d = TMR_RUN;
        end
      end
      TMR_EXPIRE: begin
        state_d = TMR_IDLE;
      end
      default: begin
        state_d     = TMR_IDLE;
        remaining_d = '0;
      end
    endcase
    if (reprogram) begin
      state_d     = TMR_IDLE;
      remaining_d = '0;
    end else if (start_timer) begin
      state_d     = TMR_RUN;
      remaining_d = load_val_s;
    end else begin
      remaining_d = remaining_d;
    end
    expired_d = (state_d == TMR_EXPIRE);
    busy_d    = (state_d == TMR_RUN);
  end

  // State, countdown, flag and parameter registers; reset beats writes and starts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= TMR_IDLE;
      remaining_q <= '0;
      expired_q   <= 1'b0;
      busy_q      <= 1'b0;
      t_base_q    <= BASE_RST;
      t_ext_q     <= EXT_RST;
      t_yel_q     <= YEL_RST;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
      busy_q      <= busy_d;
      t_base_q    <= t_base_d;
      t_ext_q     <= t_ext_d;
      t_yel_q     <= t_yel_d;
    end
  end

  assign expired   = expired_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;
  assign sec_tick  = tick_s;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl with CLK_PER_SEC = 4.
module tb_interval_timer_ctrl;

  localparam int P = 4;

  logic       clk;
  logic       reset;
  logic       prog_write;
  logic [1:0] prog_sel;
  logic [3:0] prog_value;
  logic       reprogram;
  logic [1:0] requesting_interval;
  logic       start_timer;
  logic       expired;
  logic       busy;
  logic       sec_tick;
  logic [3:0] remaining;

  int n_cmp = 0;
  int n_bad = 0;

  interval_timer_ctrl #(
    .CLK_PER_SEC(P),
    .CNT_W      (4),
    .T_BASE_DEF (6),
    .T_EXT_DEF  (3),
    .T_YEL_DEF  (2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .prog_write         (prog_write),
    .prog_sel           (prog_sel),
    .prog_value         (prog_value),
    .reprogram          (reprogram),
    .requesting_interval(requesting_interval),
    .start_timer        (start_timer),
    .expired            (expired),
    .busy               (busy),
    .sec_tick           (sec_tick),
    .remaining          (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         do_wr;
    logic [1:0] wsel;
    logic [3:0] wval;
    logic [1:0] req;
    int         exp_n;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] r);
    requesting_interval = r;
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    prog_write = 1'b1;
    prog_sel   = sel;
    prog_value = val;
    step();
    prog_write = 1'b0;
  endtask

  // Called just after the start edge; returns positioned in the expired cycle.
  task automatic track(input string tag, input int n, input int exp_lat);
    int lat = -1;
    bit seq_ok = 1'b1;
    check({tag, "/load"}, 32'(remaining), 32'(n));
    check({tag, "/busy"}, 32'(busy), 32'd1);
    for (int j = 1; j <= n * P + 8 && lat < 0; j++) begin
      if (int'(remaining) != n - (j - 1) / P || sec_tick !== ((j - 1) % P == P - 1) ||
          expired !== 1'b0 || busy !== 1'b1) seq_ok = 1'b0;
      step();
      if (expired === 1'b1) lat = j;
    end
    check({tag, "/sequence"}, 32'(seq_ok), 32'd1);
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/rem_at_expire"}, 32'(remaining), 32'd0);
    check({tag, "/busy_at_expire"}, 32'(busy), 32'd0);
  endtask

  task automatic after_expire(input string tag);
    step();
    check({tag, "/pulse_width"}, 32'(expired), 32'd0);
    check({tag, "/idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit quiet;
    vecs[0] = '{"base_default",  1'b0, 2'b00, 4'd0, 2'b00, 6, 24};
    vecs[1] = '{"yel_write5",    1'b1, 2'b10, 4'd5, 2'b10, 5, 20};
    vecs[2] = '{"base_zero_ign", 1'b1, 2'b00, 4'd0, 2'b00, 6, 24};
    vecs[3] = '{"sel11_ign",     1'b1, 2'b11, 4'd7, 2'b00, 6, 24};
    vecs[4] = '{"req11_base",    1'b0, 2'b00, 4'd0, 2'b11, 6, 24};
    vecs[5] = '{"ext_default",   1'b0, 2'b00, 4'd0, 2'b01, 3, 12};
    vecs[6] = '{"ext_write1",    1'b1, 2'b01, 4'd1, 2'b01, 1, 4};

    reset = 1'b0;
    prog_write = 1'b0;
    prog_sel = 2'b00;
    prog_value = 4'd0;
    reprogram = 1'b0;
    requesting_interval = 2'b00;
    start_timer = 1'b0;
    step();
    step();
    check("reset/expired", 32'(expired), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/sec_tick", 32'(sec_tick), 32'd0);
    check("reset/remaining", 32'(remaining), 32'd0);
    reset = 1'b1;
    step();

    // Restart: extended, then yellow five cycles later.
    start(2'b01);
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (expired !== 1'b0) quiet = 1'b0;
      step();
    end
    check("restart/no_early_expire", 32'(quiet), 32'd1);
    start(2'b10);
    track("restart", 2, 8);
    after_expire("restart");

    // Reprogram together with start mid-count.
    start(2'b00);
    for (int i = 0; i < 7; i++) step();
    reprogram = 1'b1;
    start_timer = 1'b1;
    step();
    reprogram = 1'b0;
    start_timer = 1'b0;
    check("reprog/busy", 32'(busy), 32'd0);
    check("reprog/remaining", 32'(remaining), 32'd0);
    check("reprog/expired", 32'(expired), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (expired !== 1'b0 || busy !== 1'b0 || remaining !== 4'd0) quiet = 1'b0;
      step();
    end
    check("reprog/stays_idle", 32'(quiet), 32'd1);

    // Start in the EXPIRE cycle with code 11.
    start(2'b10);
    track("exp_start_a", 2, 8);
    requesting_interval = 2'b11;
    start_timer = 1'b1;
    check("exp_start/pulse_seen", 32'(expired), 32'd1);
    step();
    start_timer = 1'b0;
    check("exp_start/pulse_ends", 32'(expired), 32'd0);
    track("exp_start_b", 6, 24);
    after_expire("exp_start_b");

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_wr) prog(vecs[v].wsel, vecs[v].wval);
      step();
      start(vecs[v].req);
      track(vecs[v].name, vecs[v].exp_n, vecs[v].exp_lat);
      after_expire(vecs[v].name);
    end

    // Mid-count reset after reprogramming base to 9.
    prog(2'b00, 4'd9);
    start(2'b00);
    check("midreset/load9", 32'(remaining), 32'd9);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midreset/expired", 32'(expired), 32'd0);
    check("midreset/busy", 32'(busy), 32'd0);
    check("midreset/sec_tick", 32'(sec_tick), 32'd0);
    check("midreset/remaining", 32'(remaining), 32'd0);
    step();
    start(2'b00);
    track("post_reset_base", 6, 24);
    after_expire("post_reset_base");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Programmable interval timer that sequences the countdown behind the traffic controller FSM. It stores the base, extended and yellow durations, loads the requested one on `start_timer`, and counts it down in one-second ticks. It returns a single-cycle `expired` pulse to the FSM. It sits between the FSM (`requesting_interval`, `start_timer`, `reprogram`) and the operator programming inputs.

## Interface
Parameters:
- `CLK_PER_SEC`, default 4: clock cycles per one-second tick. Minimum 2. The sim default is small; synthesis sets the board value.
- `CNT_W`, default 4: width of time values and of the countdown.
- `T_BASE_DEF`, default 6: reset value of the base interval, in seconds.
- `T_EXT_DEF`, default 3: reset value of the extended interval.
- `T_YEL_DEF`, default 2: reset value of the yellow interval.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `reset`, in, 1: synchronous, active-low. 0 on a rising edge resets the block.
- `prog_write`, in, 1: one-cycle write strobe for a time parameter.
- `prog_sel`, in, 2: parameter to write. 00 base, 01 extended, 10 yellow, 11 ignored.
- `prog_value`, in, CNT_W: new duration in seconds.
- `reprogram`, in, 1: abort request. Stops any running countdown without issuing `expired`.
- `requesting_interval`, in, 2: interval for the next load. 00 base, 01 extended, 10 yellow, 11 treated as base.
- `start_timer`, in, 1: load and start a countdown.
- `expired`, out, 1: one-cycle pulse when the countdown reaches 0.
- `busy`, out, 1: high while in RUN.
- `sec_tick`, out, 1: one-cycle pulse when the prescaler wraps. Shared with the walk logic.
- `remaining`, out, CNT_W: current countdown value.

## Operation
- States: IDLE, RUN, EXPIRE.
  - IDLE → RUN on `start_timer`.
  - RUN → EXPIRE on a tick while `remaining`==1.
  - EXPIRE → IDLE unconditionally.
- `start_timer` sampled in any state:
  - loads `remaining` with the selected parameter;
  - clears the prescaler;
  - next state is RUN.
  - In RUN this restarts the countdown.
  - In EXPIRE the `expired` pulse for that cycle is still issued.
- Prescaler:
  - counts 0..CLK_PER_SEC-1 and runs only in RUN.
  - `sec_tick` is high in the cycle where prescaler == CLK_PER_SEC-1.
  - On that edge `remaining` decrements.
- Parameter registers: three CNT_W registers, reset to the defaults.
  - `prog_write` with `prog_sel`≠11 and `prog_value`≠0 updates the selected register on that edge.
  - A zero value or `prog_sel`=11 is ignored.
  - A write never affects a running countdown; it applies at the next load.
- Same-edge write and `start_timer` on the same register: the load uses the pre-write value.
- `reprogram`:
  - forces IDLE and clears `remaining` and the prescaler;
  - no `expired` is issued;
  - has priority over `start_timer` in the same cycle;
  - leaves parameter registers unchanged.
- `reset`=0: all state returns to the reset values. Parameters revert to the defaults, overriding any simultaneous write or start.

## Timing
- Reset values: `expired`=0, `busy`=0, `sec_tick`=0, `remaining`=0, state IDLE, prescaler 0.
- `start_timer` sampled at edge k with selected value N:
  - `busy` and `remaining`=N are visible after edge k;
  - decrements occur at edges k+P, k+2P, …, k+N·P, where P=CLK_PER_SEC;
  - `expired` is high for exactly the one cycle after edge k+N·P.
- `busy` is low during the EXPIRE cycle.
- All outputs are registered except `sec_tick`, which is decoded from the prescaler register. No combinational input-to-output paths.

## Structure
- Shared package `traffic_pkg` holds:
  - interval codes (`INT_BASE`, `INT_EXT`, `INT_YEL`);
  - the timer state enum;
  - the default duration constants, shared with the FSM.
- One sub-module, `sec_prescaler`, with ports `clk`, `reset`, `enable`, `clear` and `tick`. The countdown, parameter registers and FSM stay in `interval_timer_ctrl`.

## Test plan
All scenarios use P=4.
- Reset, then `start_timer` with base (00) → `expired` high exactly 24 cycles after the start edge, single cycle; `remaining` steps 6,5,…,1,0.
- Write yellow = 5, then start yellow (10) → `expired` 20 cycles later. Writing 0 or `prog_sel`=11 leaves the defaults intact (base still 24 cycles).
- Start extended, then after 5 cycles `start_timer` again with yellow → count restarts at 2; `expired` 8 cycles after the second start; no earlier pulse.
- Start base, then `reprogram` together with `start_timer` mid-count → IDLE, `remaining`=0, `busy`=0, no `expired` ever.
- `start_timer` with `requesting_interval`=11 → behaves as base. `start_timer` in the EXPIRE cycle → `expired` still pulses and the new count begins.
- Drive `reset`=0 mid-count after writing base=9 → all outputs at reset values next cycle; a following base start expires after 24 cycles.
